n_demux: RTL and testbench

//   Inverse of the N-way byte selector. One input byte stream with a lane select

---
 rtl/n_demux.sv | 71 +++++++
 tb/tb_n_demux.sv | 128 ++++++++++++
 2 files changed

// File: rtl/n_demux.sv
// n_demux: steers one valid/ready byte stream to one of N one-entry output lanes
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   io_in_valid   producer offers io_in_data / io_in_sel
//   io_in_ready   block accepts this cycle (combinational)
//   io_in_data    payload byte
//   io_in_sel     destination lane index; values >= N are dropped and counted
//   io_Dvect_out  lane k data at [k*W +: W] (registered)
//   io_out_valid  bit k: lane k holds a byte
//   io_out_ready  bit k: consumer k takes lane k this cycle
//   io_err_cnt    saturating count of dropped bad-select transfers
module n_demux #(
    parameter int N    = 5,
    parameter int W    = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [W-1:0]    io_in_data,
    input  logic [SELW-1:0] io_in_sel,
    output logic [N*W-1:0]  io_Dvect_out,
    output logic [N-1:0]    io_out_valid,
    input  logic [N-1:0]    io_out_ready,
    output logic [7:0]      io_err_cnt
);
    localparam logic [SELW:0] N_L = N;

    logic [N*W-1:0] r_data;
    logic [N-1:0]   r_valid;
    logic [7:0]     r_err;
    logic [N-1:0]   w_free;
    logic           w_sel_ok;
    logic           w_acc;

    // A lane can take a new byte when empty or when its current byte leaves this cycle
    assign w_free      = ~r_valid | io_out_ready;
    assign w_sel_ok    = {1'b0, io_in_sel} < N_L;
    // Bad selects are always accepted so they can be sunk and counted
    assign io_in_ready = reset_n & (w_sel_ok ? w_free[io_in_sel] : 1'b1);
    assign w_acc       = io_in_valid & io_in_ready;

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam logic [SELW-1:0] K = k;
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_data[k*W +: W] <= '0;
                r_valid[k]       <= 1'b0;
            end else if (w_acc && io_in_sel == K) begin
                r_data[k*W +: W] <= io_in_data;
                r_valid[k]       <= 1'b1;
            end else if (io_out_ready[k]) begin
                r_valid[k]       <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_err <= '0;
        else if (w_acc && !w_sel_ok && r_err != 8'hFF)
            r_err <= r_err + 8'd1;
    end

    assign io_Dvect_out = r_data;
    assign io_out_valid = r_valid;
    assign io_err_cnt   = r_err;
endmodule

// File: tb/tb_n_demux.sv
// tb_n_demux: table-driven directed check of n_demux steering, stall, drop and reset
module tb_n_demux;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [7:0]  io_in_data;
    logic [2:0]  io_in_sel;
    logic [39:0] io_Dvect_out;
    logic [4:0]  io_out_valid;
    logic [4:0]  io_out_ready;
    logic [7:0]  io_err_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    n_demux #(.N(5), .W(8), .SELW(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready),
        .io_in_data(io_in_data),
        .io_in_sel(io_in_sel),
        .io_Dvect_out(io_Dvect_out),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_err_cnt(io_err_cnt)
    );

    typedef struct {
        logic        rn;
        logic        v;
        logic [2:0]  sel;
        logic [7:0]  d;
        logic [4:0]  ordy;
        logic        e_rdy;
        logic [4:0]  e_ov;
        logic [39:0] e_dv;
        logic [7:0]  e_err;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic v, input logic [2:0] sel,
                         input logic [7:0] d, input logic [4:0] ordy);
        reset_n      = rn;
        io_in_valid  = v;
        io_in_sel    = sel;
        io_in_data   = d;
        io_out_ready = ordy;
    endtask

    initial begin
        // reset with valid traffic offered
        tv[0]  = '{1'b0, 1'b1, 3'd0, 8'hAA, 5'h00, 1'b0, 5'h00, 40'h00_00_00_00_00, 8'd0};
        tv[1]  = '{1'b0, 1'b1, 3'd0, 8'hAA, 5'h00, 1'b0, 5'h00, 40'h00_00_00_00_00, 8'd0};
        // steer with all consumers ready
        tv[2]  = '{1'b1, 1'b1, 3'd0, 8'h11, 5'h1F, 1'b1, 5'h01, 40'h00_00_00_00_11, 8'd0};
        tv[3]  = '{1'b1, 1'b1, 3'd2, 8'h22, 5'h1F, 1'b1, 5'h04, 40'h00_00_22_00_11, 8'd0};
        tv[4]  = '{1'b1, 1'b1, 3'd4, 8'h44, 5'h1F, 1'b1, 5'h10, 40'h44_00_22_00_11, 8'd0};
        tv[5]  = '{1'b1, 1'b0, 3'd0, 8'h00, 5'h1F, 1'b1, 5'h00, 40'h44_00_22_00_11, 8'd0};
        // lane 3 stalled, then pass-through on release
        tv[6]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 5'h17, 1'b1, 5'h08, 40'h44_A5_22_00_11, 8'd0};
        tv[7]  = '{1'b1, 1'b1, 3'd3, 8'h5A, 5'h17, 1'b0, 5'h08, 40'h44_A5_22_00_11, 8'd0};
        tv[8]  = '{1'b1, 1'b1, 3'd3, 8'h5A, 5'h1F, 1'b1, 5'h08, 40'h44_5A_22_00_11, 8'd0};
        // lane 1 stalled and full, lane 0 independent
        tv[9]  = '{1'b1, 1'b1, 3'd1, 8'h77, 5'h1D, 1'b1, 5'h02, 40'h44_5A_22_77_11, 8'd0};
        tv[10] = '{1'b1, 1'b1, 3'd0, 8'h01, 5'h1D, 1'b1, 5'h03, 40'h44_5A_22_77_01, 8'd0};
        tv[11] = '{1'b1, 1'b1, 3'd1, 8'h99, 5'h1D, 1'b0, 5'h02, 40'h44_5A_22_77_01, 8'd0};
        // bad selects sunk and counted
        tv[12] = '{1'b1, 1'b1, 3'd5, 8'hFF, 5'h1D, 1'b1, 5'h02, 40'h44_5A_22_77_01, 8'd1};
        tv[13] = '{1'b1, 1'b1, 3'd6, 8'hFF, 5'h1D, 1'b1, 5'h02, 40'h44_5A_22_77_01, 8'd2};
        tv[14] = '{1'b1, 1'b1, 3'd7, 8'hFF, 5'h1D, 1'b1, 5'h02, 40'h44_5A_22_77_01, 8'd3};
        // fill lanes 0 and 2, reset mid-operation, then normal delivery
        tv[15] = '{1'b1, 1'b1, 3'd0, 8'hC0, 5'h00, 1'b1, 5'h03, 40'h44_5A_22_77_C0, 8'd3};
        tv[16] = '{1'b1, 1'b1, 3'd2, 8'hC2, 5'h00, 1'b1, 5'h07, 40'h44_5A_C2_77_C0, 8'd3};
        tv[17] = '{1'b0, 1'b1, 3'd2, 8'h33, 5'h00, 1'b0, 5'h00, 40'h00_00_00_00_00, 8'd0};
        tv[18] = '{1'b1, 1'b1, 3'd2, 8'h33, 5'h00, 1'b1, 5'h04, 40'h00_00_33_00_00, 8'd0};
        tv[19] = '{1'b1, 1'b0, 3'd2, 8'h00, 5'h1F, 1'b1, 5'h00, 40'h00_00_33_00_00, 8'd0};

        drive(1'b0, 1'b0, 3'd0, 8'h00, 5'h00);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            drive(tv[i].rn, tv[i].v, tv[i].sel, tv[i].d, tv[i].ordy);
            #1;
            chk($sformatf("in_ready[%0d]", i), 64'(io_in_ready), 64'(tv[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("out_valid[%0d]", i), 64'(io_out_valid), 64'(tv[i].e_ov));
            chk($sformatf("dvect[%0d]", i), 64'(io_Dvect_out), 64'(tv[i].e_dv));
            chk($sformatf("err_cnt[%0d]", i), 64'(io_err_cnt), 64'(tv[i].e_err));
        end

        // saturation: 260 bad transfers from a zero count
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 1'b1, 3'(5 + i % 3), 8'hFF, 5'h00);
            #1;
            if (i % 50 == 0)
                chk($sformatf("bad_ready[%0d]", i), 64'(io_in_ready), 64'd1);
            @(posedge clk);
            #1;
            if (i == 254)
                chk("err_at_255", 64'(io_err_cnt), 64'd255);
            if (i == 9)
                chk("err_at_10", 64'(io_err_cnt), 64'd10);
        end
        chk("err_saturated", 64'(io_err_cnt), 64'd255);
        chk("bad_no_lane", 64'(io_out_valid), 64'h04 & 64'h00);
        drive(1'b1, 1'b0, 3'd0, 8'h00, 5'h00);
        @(posedge clk);
        #1;
        chk("err_hold", 64'(io_err_cnt), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
